mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEMORY_SIZE, default 32, meaning memory depth in 16-bit words.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, meaning requester/memory address width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive data grants tolerated while fetch waits.
REQ-004 SHALL have ports clk input 1 (sole clock) and rst input 1 (reset; synchronous, active-high).
REQ-005 SHALL have fetch ports: if_req in 1, if_addr in ADDR_WIDTH, if_gnt out 1, if_rdata out 16, if_rvalid out 1.
REQ-006 SHALL have data ports: d_req in 1, d_we in 1, d_addr in ADDR_WIDTH, d_wdata in 16, d_gnt out 1, d_rdata out 16, d_rvalid out 1.
REQ-007 SHALL have memory ports: mem_en out 1, mem_we out 1, mem_addr out ADDR_WIDTH, mem_wdata out 16, mem_rdata in 16 (registered read, 1-cycle latency).
REQ-008 SHALL have err out 1: pulse flagging an out-of-range access.

Function
REQ-009 SHALL use states IDLE and RESP; IDLE->RESP on any grant; RESP->IDLE unconditionally after one cycle.
REQ-010 SHALL in IDLE grant at most one requester per cycle; if_gnt/d_gnt combinational from req, state, priority.
REQ-011 SHALL in RESP assert no grant and keep mem_en low; max throughput one access per 2 cycles.
REQ-012 SHALL with both requests in IDLE grant data, except as REQ-024 overrides.
REQ-013 SHALL during a grant cycle drive mem_addr, mem_we (d_we for data, 0 for fetch), mem_wdata (d_wdata) from the winner, mem_en=1.
REQ-014 SHALL with no grant drive mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-015 SHALL pulse winner's rvalid for exactly one cycle in RESP, with rdata=mem_rdata for reads.
REQ-016 SHALL pulse d_rvalid in RESP as write acknowledge; d_rdata then 0.
REQ-017 SHALL hold if_rdata/d_rdata at last value when rvalid is low; only the winner's rdata updates.
REQ-018 SHALL require requesters hold req, addr, wdata, we stable until gnt; req dropped before gnt is legal, causes no access.
REQ-019 SHALL treat address >= MEMORY_SIZE as out of range: grant issued, mem_en=0, RESP rvalid with rdata=0, err=1 same cycle.
REQ-020 SHALL never assert if_gnt and d_gnt in the same cycle, nor both rvalids.
REQ-021 SHALL let a requester asserting req during its rvalid cycle win no earlier than the following IDLE cycle.

Reset
REQ-022 SHALL when rst sampled high: state=IDLE, gnts=0, rvalids=0, err=0, rdata=0, starve counter=0, memory outputs=0.
REQ-023 SHALL drop an in-flight RESP when reset hits mid-transaction: no rvalid after reset; a write granted before the reset edge stays committed.

Configuration
REQ-024 SHALL with ARB_STARVE_GUARD_EN defined count consecutive data grants while if_req high (reset to 0 on any fetch grant or if_req low); at count==STARVE_LIMIT grant fetch on next contended IDLE cycle.
REQ-025 SHALL without ARB_STARVE_GUARD_EN use strict data priority, no counter logic; fetch may starve indefinitely.

Verification
REQ-026 Fetch only: if_req=1, if_addr=3, mem[3]=16'h1234 -> if_gnt cycle N, if_rvalid cycle N+1, if_rdata=16'h1234, next grant no earlier than N+2.
REQ-027 Data write then read: d_we=1 d_addr=5 d_wdata=16'hBEEF, then d_we=0 d_addr=5 -> d_rvalid pulse per access, second d_rdata=16'hBEEF.
REQ-028 Contention, guard off: if_req and d_req held high 20 cycles -> only d_gnt pulses (every 2 cycles), if_gnt never.
REQ-029 Contention, guard on, STARVE_LIMIT=4: same stimulus -> 4 d_gnt pulses, then 1 if_gnt, pattern repeats.
REQ-030 Out of range: d_addr=32 with MEMORY_SIZE=32 -> d_gnt, mem_en=0, next cycle d_rvalid=1, d_rdata=0, err=1.
REQ-031 Reset in RESP: grant fetch, assert rst next cycle -> if_rvalid stays 0, all outputs 0, new if_req granted first cycle after rst low.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (fetch/data) arbiter in front of a 1-cycle-latency memory.
// Define ARB_STARVE_GUARD_EN to let fetch win after STARVE_LIMIT consecutive data grants.
module mem_arbiter #(
    parameter int MEMORY_SIZE  = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic [15:0]           if_rdata,
    output logic                  if_rvalid,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [15:0]           d_wdata,
    output logic                  d_gnt,
    output logic [15:0]           d_rdata,
    output logic                  d_rvalid,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata,
    output logic                  err
);
    typedef enum logic {IDLE, RESP} state_t;
    localparam logic [31:0] MEM_SIZE_U = MEMORY_SIZE;
    state_t state_q, state_d;
    logic own_d_q, own_d_d, we_q, we_d, oor_q, oor_d;
    logic [15:0] if_hold_q, if_hold_d, d_hold_q, d_hold_d, resp_data;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic fetch_pri, idle, resp, gnt, oor;
`ifdef ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        fetch_pri = cnt_q == CW'(STARVE_LIMIT);
        cnt_d     = cnt_q;
        if (!if_req || if_gnt) cnt_d = '0;
        else if (d_gnt && !fetch_pri) cnt_d = cnt_q + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    assign fetch_pri = 1'b0;
`endif
    // Reset masks outputs combinationally so an in-flight RESP never shows rvalid.
    always_comb begin
        idle      = state_q == IDLE && !rst;
        resp      = state_q == RESP && !rst;
        d_gnt     = idle && d_req && !(fetch_pri && if_req);
        if_gnt    = idle && if_req && !d_gnt;
        gnt       = if_gnt || d_gnt;
        sel_addr  = d_gnt ? d_addr : if_addr;
        oor       = 32'(sel_addr) >= MEM_SIZE_U;
        mem_en    = gnt && !oor;
        mem_we    = mem_en && d_gnt && d_we;
        mem_addr  = gnt ? sel_addr : '0;
        mem_wdata = d_gnt ? d_wdata : '0;
        if_rvalid = resp && !own_d_q;
        d_rvalid  = resp && own_d_q;
        err       = resp && oor_q;
        resp_data = (oor_q || we_q) ? 16'h0 : mem_rdata;
        if_rdata  = if_rvalid ? resp_data : if_hold_q;
        d_rdata   = d_rvalid ? resp_data : d_hold_q;
        state_d   = gnt ? RESP : IDLE;
        own_d_d   = gnt ? d_gnt : own_d_q;
        we_d      = gnt ? (d_gnt && d_we) : we_q;
        oor_d     = gnt ? oor : oor_q;
        if_hold_d = if_rdata;
        d_hold_d  = d_rdata;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            own_d_q   <= 1'b0;
            we_q      <= 1'b0;
            oor_q     <= 1'b0;
            if_hold_q <= '0;
            d_hold_q  <= '0;
        end else begin
            state_q   <= state_d;
            own_d_q   <= own_d_d;
            we_q      <= we_d;
            oor_q     <= oor_d;
            if_hold_q <= if_hold_d;
            d_hold_q  <= d_hold_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a behavioural 32-word memory.
module tb_mem_arbiter;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [15:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, err;
  logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [15:0] mem [0:31];
  int n_tests = 0, n_fail = 0;
  logic exp_d, exp_f;
  mem_arbiter #(.MEMORY_SIZE(32), .ADDR_WIDTH(16), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata), .if_rvalid(if_rvalid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rdata(d_rdata), .d_rvalid(d_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .err(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (rst) mem[3] <= 16'h1234;
    else if (mem_en) begin
      if (mem_we) mem[mem_addr[4:0]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[4:0]];
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    if_req = 1'b1;
    tick();
    tick();
    #1;
    chk("rst_if_gnt", if_gnt, 1'b0);
    chk("rst_d_gnt", d_gnt, 1'b0);
    chk("rst_if_rvalid", if_rvalid, 1'b0);
    chk("rst_d_rvalid", d_rvalid, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0);
    chk("rst_if_rdata", if_rdata, 16'h0);
    chk("rst_d_rdata", d_rdata, 16'h0);
    tick();
    rst = 1'b0;
    if_addr = 16'd3;
    #1;
    chk("fetch_gnt", if_gnt, 1'b1);
    chk("fetch_mem_en", mem_en, 1'b1);
    chk("fetch_mem_addr", mem_addr, 16'd3);
    chk("fetch_mem_we", mem_we, 1'b0);
    tick();
    #1;
    chk("fetch_resp_no_gnt", if_gnt, 1'b0);
    chk("fetch_resp_mem_en", mem_en, 1'b0);
    chk("fetch_rvalid", if_rvalid, 1'b1);
    chk("fetch_rdata", if_rdata, 16'h1234);
    chk("fetch_no_d_rvalid", d_rvalid, 1'b0);
    if_req = 1'b0;
    tick();
    #1;
    chk("fetch_rvalid_drop", if_rvalid, 1'b0);
    chk("fetch_rdata_hold", if_rdata, 16'h1234);
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'd5; d_wdata = 16'hBEEF;
    #1;
    chk("wr_gnt", d_gnt, 1'b1);
    chk("wr_mem_we", mem_we, 1'b1);
    chk("wr_mem_addr", mem_addr, 16'd5);
    chk("wr_mem_wdata", mem_wdata, 16'hBEEF);
    tick();
    d_we = 1'b0;
    #1;
    chk("wr_ack", d_rvalid, 1'b1);
    chk("wr_ack_rdata", d_rdata, 16'h0);
    chk("wr_if_rdata_hold", if_rdata, 16'h1234);
    chk("wr_resp_no_gnt", d_gnt, 1'b0);
    tick();
    #1;
    chk("rd_gnt", d_gnt, 1'b1);
    chk("rd_mem_we", mem_we, 1'b0);
    tick();
    d_req = 1'b0;
    #1;
    chk("rd_rvalid", d_rvalid, 1'b1);
    chk("rd_rdata", d_rdata, 16'hBEEF);
    tick();
    #1;
    chk("rd_rvalid_drop", d_rvalid, 1'b0);
    chk("rd_rdata_hold", d_rdata, 16'hBEEF);
    if_req = 1'b1; if_addr = 16'd3; d_req = 1'b1; d_addr = 16'd5;
    for (int k = 0; k < 20; k++) begin
      #1;
      exp_f = (k % 2 == 0) && GUARD && ((k / 2) % 5 == 4);
      exp_d = (k % 2 == 0) && !exp_f;
      chk("cont_d_gnt", d_gnt, exp_d);
      chk("cont_if_gnt", if_gnt, exp_f);
      tick();
    end
    if_req = 1'b0; d_req = 1'b0;
    tick();
    d_req = 1'b1; d_addr = 16'd32;
    #1;
    chk("oor_gnt", d_gnt, 1'b1);
    chk("oor_mem_en", mem_en, 1'b0);
    chk("oor_err_early", err, 1'b0);
    tick();
    d_req = 1'b0;
    #1;
    chk("oor_rvalid", d_rvalid, 1'b1);
    chk("oor_rdata", d_rdata, 16'h0);
    chk("oor_err", err, 1'b1);
    tick();
    #1;
    chk("oor_err_drop", err, 1'b0);
    if_req = 1'b1; if_addr = 16'd3;
    #1;
    chk("rr_gnt", if_gnt, 1'b1);
    tick();
    rst = 1'b1;
    #1;
    chk("rr_no_rvalid", if_rvalid, 1'b0);
    tick();
    #1;
    chk("rr_after_rvalid", if_rvalid, 1'b0);
    chk("rr_after_gnt", if_gnt, 1'b0);
    chk("rr_after_rdata", if_rdata, 16'h0);
    chk("rr_after_mem_en", mem_en, 1'b0);
    rst = 1'b0;
    #1;
    chk("rr_regrant", if_gnt, 1'b1);
    tick();
    #1;
    chk("rr_rvalid", if_rvalid, 1'b1);
    chk("rr_rdata", if_rdata, 16'h1234);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
